// File: rtl/lsu_pipe.sv
// lsu_pipe: load/store unit between execute and data memory, with a hold
// register for issue, an in-order tracking FIFO and a registered writeback.
// Ports: req_* (core request, valid/ready), mem_* (memory request/response),
// wb_* (load result, valid/ready), misalign_o/err_addr_o (misaligned access),
// busy_o (any work held, outstanding or awaiting writeback).
module lsu_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RD_W    = 5,
  parameter int MAX_OUT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_signed_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [RD_W-1:0]     req_rd_i,
  output logic                mem_valid_o,
  input  logic                mem_yumi_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic                mem_wen_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                mem_ryumi_o,
  output logic                wb_valid_o,
  output logic [RD_W-1:0]     wb_rd_o,
  output logic [DATA_W-1:0]   wb_data_o,
  input  logic                wb_ready_i,
  output logic                misalign_o,
  output logic [ADDR_W-1:0]   err_addr_o,
  output logic                busy_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic             wen;
    logic [1:0]       size;
    logic             sgn;
    logic [OFF_W-1:0] off;
    logic [RD_W-1:0]  rd;
  } trk_t;

  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [BE_W-1:0]   hold_be_q, hold_be_d;
  logic              hold_wen_q, hold_wen_d;

  trk_t              fifo_q [MAX_OUT];
  trk_t              fifo_d [MAX_OUT];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              xfer, mis, push, pop, load_pop;
  logic [OFF_W-1:0]  req_off;
  logic [BE_W-1:0]   lane_mask, req_be;
  logic [DATA_W-1:0] req_wdata_rep;
  trk_t              req_trk, head;
  logic [DATA_W-1:0] rsp_shift, rsp_ext;
  logic              rsp_sbit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUT - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign req_ready_o = !hold_valid_q && (count_q < CNT_W'(MAX_OUT));
  assign xfer        = req_valid_i && req_ready_o;
  assign push        = xfer && !mis;
  assign req_off     = req_addr_i[OFF_W-1:0];
  assign req_be      = lane_mask << req_off;
  assign req_trk     = {req_wen_i, req_size_i, req_signed_i, req_off, req_rd_i};
  assign head        = fifo_q[rd_ptr_q];

  // Stores never stall on writeback; loads need the wb slot free or draining.
  assign mem_ryumi_o = mem_rvalid_i && (count_q != '0) &&
                       (head.wen || !wb_valid_q || wb_ready_i);
  assign pop         = mem_ryumi_o;
  assign load_pop    = pop && !head.wen;

  // A dword on a 32-bit bus cannot be served, so it is trapped as misaligned.
  always_comb begin
    mis = 1'b0;
    unique case (req_size_i)
      2'd0:    mis = 1'b0;
      2'd1:    mis = req_addr_i[0];
      2'd2:    mis = |req_addr_i[1:0];
      default: mis = (|req_addr_i[2:0]) || (DATA_W < 64);
    endcase
  end

  always_comb begin
    lane_mask     = '0;
    req_wdata_rep = '0;
    for (int i = 0; i < BE_W; i++) begin
      lane_mask[i] = (i < (1 << req_size_i));
      req_wdata_rep[8*i +: 8] =
        req_wdata_i[8*(i & ((1 << req_size_i) - 1)) +: 8];
    end
  end

  always_comb begin
    rsp_shift = mem_rdata_i >> {head.off, 3'b000};
    rsp_sbit  = 1'b0;
    rsp_ext   = '0;
    unique case (head.size)
      2'd0:    rsp_sbit = rsp_shift[7];
      2'd1:    rsp_sbit = rsp_shift[15];
      2'd2:    rsp_sbit = rsp_shift[31];
      default: rsp_sbit = rsp_shift[DATA_W-1];
    endcase
    rsp_sbit = rsp_sbit && head.sgn;
    for (int i = 0; i < DATA_W; i++) begin
      rsp_ext[i] = (i < (8 << head.size)) ? rsp_shift[i] : rsp_sbit;
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_be_d    = hold_be_q;
    hold_wen_d   = hold_wen_q;
    if (hold_valid_q) begin
      if (mem_yumi_i) hold_valid_d = 1'b0;
    end else if (push) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = req_addr_i;
      hold_wdata_d = req_wdata_rep;
      hold_be_d    = req_be;
      hold_wen_d   = req_wen_i;
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = req_trk;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    misalign_d = xfer && mis;
    err_addr_d = (xfer && mis) ? req_addr_i : err_addr_q;

    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (load_pop) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = head.rd;
      wb_data_d  = rsp_ext;
    end else if (wb_ready_i) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_be_q    <= '0;
      hold_wen_q   <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misalign_q   <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_be_q    <= hold_be_d;
      hold_wen_q   <= hold_wen_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misalign_q   <= misalign_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign mem_valid_o = hold_valid_q;
  assign mem_addr_o  = hold_addr_q;
  assign mem_wdata_o = hold_wdata_q;
  assign mem_be_o    = hold_be_q;
  assign mem_wen_o   = hold_wen_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign misalign_o  = misalign_q;
  assign err_addr_o  = err_addr_q;
  assign busy_o      = hold_valid_q || (count_q != '0) || wb_valid_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: directed bench for lsu_pipe with a memory model,
// a writeback scoreboard and a decoupled monitor.
module tb_lsu_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid_i, req_ready_o, req_wen_i, req_signed_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        mem_valid_o, mem_wen_o, mem_ryumi_o;
  logic        mem_yumi_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o, busy_o;
  logic [31:0] err_addr_o;

  lsu_pipe #(.DATA_W(32), .ADDR_W(32), .RD_W(5), .MAX_OUT(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_wen_i(req_wen_i), .req_size_i(req_size_i),
    .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .mem_valid_o(mem_valid_o), .mem_yumi_i(mem_yumi_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_wen_o(mem_wen_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_ryumi_o(mem_ryumi_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_ready_i(wb_ready_i),
    .misalign_o(misalign_o), .err_addr_o(err_addr_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { int due; logic [31:0] rdata; } rsp_t;
  wb_t         sb[$];
  rsp_t        pend[$];
  logic [31:0] rdata_q[$];

  int cyc = 0, rsp_delay = 0, rsp_pops = 0, mem_hs = 0;
  bit yumi_en = 1'b1;
  logic [31:0] hs_addr, hs_wdata;
  logic [3:0]  hs_be;
  logic        hs_wen;
  int waited, pops_at_acc;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: drives at negedge, records handshakes for the next edge.
  always @(negedge clk) begin
    rsp_t r;
    mem_yumi_i   = yumi_en && mem_valid_o && !reset;
    mem_rvalid_i = !reset && (pend.size() > 0) && (pend[0].due <= cyc);
    mem_rdata_i  = (pend.size() > 0) ? pend[0].rdata : 32'h0;
    #1;
    if (!reset) begin
      if (mem_valid_o && mem_yumi_i) begin
        mem_hs++;
        hs_addr  = mem_addr_o;
        hs_wdata = mem_wdata_o;
        hs_be    = mem_be_o;
        hs_wen   = mem_wen_o;
        r.due    = cyc + 1 + rsp_delay;
        r.rdata  = 32'h0;
        if (rdata_q.size() > 0) r.rdata = rdata_q.pop_front();
        pend.push_back(r);
      end
      if (mem_rvalid_i && mem_ryumi_o) begin
        void'(pend.pop_front());
        rsp_pops++;
      end
    end
    cyc++;
  end

  // Monitor: compares each writeback handshake with the scoreboard head.
  always @(negedge clk) begin
    wb_t e;
    #3;
    if (!reset && wb_valid_o && wb_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd %0d data 0x%0h want none",
                 wb_rd_o, wb_data_o);
      end else begin
        e = sb.pop_front();
        if (wb_rd_o !== e.rd || wb_data_o !== e.data) begin
          errors++;
          $display("FAIL wb_data: got rd %0d 0x%0h want rd %0d 0x%0h",
                   wb_rd_o, wb_data_o, e.rd, e.data);
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] rdata, input logic [31:0] exp,
                       input bit mis);
    int n = 0;
    wb_t e;
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_wen_i    = wen;
    req_size_i   = size;
    req_signed_i = sgn;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_rd_i     = rd;
    if (!mis) rdata_q.push_back(rdata);
    if (!mis && !wen) begin
      e.rd = rd;
      e.data = exp;
      sb.push_back(e);
    end
    #2;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    waited = n;
    pops_at_acc = rsp_pops;
    if (!req_ready_o) check("accept_timeout", 0, 1);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < 100) begin
      @(negedge clk);
      #4;
      n++;
    end
    check(name, (sb.size() == 0 && !busy_o), 1);
  endtask

  task automatic wait_hs(input int base);
    int n = 0;
    while (mem_hs == base && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("mem_hs_seen", mem_hs > base, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n;
    reset = 1'b1;
    req_valid_i = 0; req_wen_i = 0; req_size_i = 0; req_signed_i = 0;
    req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0; wb_ready_i = 1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", req_ready_o, 1);
    check("rst_outs", {mem_valid_o, wb_valid_o, misalign_o, busy_o,
                       mem_ryumi_o}, 0);
    check("rst_err_addr", err_addr_o, 0);

    // Loads with extension
    issue(0, 0, 1, 32'h103, 0, 1, 32'h80FF_0000, 32'hFFFF_FF80, 0);
    issue(0, 0, 0, 32'h103, 0, 2, 32'h80FF_0000, 32'h0000_0080, 0);
    issue(0, 1, 1, 32'h102, 0, 3, 32'h80FF_0000, 32'hFFFF_80FF, 0);
    issue(0, 2, 0, 32'h104, 0, 4, 32'h1234_5678, 32'h1234_5678, 0);
    issue(0, 1, 0, 32'h106, 0, 5, 32'h8001_0000, 32'h0000_8001, 0);
    drain("drain_loads");

    // Stores, first one stalled by memory
    yumi_en = 1'b0;
    base = mem_hs;
    issue(1, 1, 0, 32'h102, 32'h0000_BEEF, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sh_stall_ctl", {mem_valid_o, mem_wen_o, mem_be_o, mem_addr_o},
            {1'b1, 1'b1, 4'b1100, 32'h102});
      check("sh_stall_wdata", mem_wdata_o, 32'hBEEF_BEEF);
      @(negedge clk);
    end
    yumi_en = 1'b1;
    wait_hs(base);
    check("sh_hs", {hs_wen, hs_be, hs_addr, hs_wdata},
          {1'b1, 4'b1100, 32'h102, 32'hBEEF_BEEF});
    base = mem_hs;
    issue(1, 0, 0, 32'h101, 32'h0000_00A5, 0, 0, 0, 0);
    wait_hs(base);
    check("sb_hs", {hs_wen, hs_be, hs_addr, hs_wdata},
          {1'b1, 4'b0010, 32'h101, 32'hA5A5_A5A5});
    base = mem_hs;
    issue(1, 2, 0, 32'h100, 32'hCAFE_F00D, 0, 0, 0, 0);
    wait_hs(base);
    check("sw_hs", {hs_wen, hs_be, hs_addr, hs_wdata},
          {1'b1, 4'b1111, 32'h100, 32'hCAFE_F00D});
    drain("drain_stores");

    // Outstanding limit with delayed responses
    rsp_delay = 5;
    base = rsp_pops;
    issue(0, 2, 0, 32'h100, 0, 1, 32'hAAAA_0001, 32'hAAAA_0001, 0);
    issue(0, 2, 0, 32'h104, 0, 2, 32'hBBBB_0002, 32'hBBBB_0002, 0);
    issue(0, 2, 0, 32'h108, 0, 3, 32'hCCCC_0003, 32'hCCCC_0003, 0);
    check("third_stalled", waited > 0, 1);
    check("third_after_pop", pops_at_acc >= base + 1, 1);
    drain("drain_maxout");
    rsp_delay = 0;

    // Misalignment
    base = mem_hs;
    issue(0, 2, 0, 32'h6, 0, 9, 0, 0, 1);
    #1;
    check("lw_mis_pulse", misalign_o, 1);
    check("lw_mis_addr", err_addr_o, 32'h6);
    check("lw_mis_quiet", {mem_valid_o, busy_o}, 0);
    @(negedge clk);
    #1;
    check("lw_mis_end", {misalign_o, mem_valid_o, busy_o}, 0);
    issue(0, 1, 1, 32'h101, 0, 9, 0, 0, 1);
    #1;
    check("lh_mis_pulse", {misalign_o, err_addr_o}, {1'b1, 32'h101});
    repeat (3) @(negedge clk);
    check("mis_no_mem", mem_hs, base);

    // Writeback backpressure
    wb_ready_i = 1'b0;
    issue(0, 2, 0, 32'h100, 0, 6, 32'h1111_1111, 32'h1111_1111, 0);
    issue(0, 2, 0, 32'h104, 0, 7, 32'h2222_2222, 32'h2222_2222, 0);
    n = 0;
    #2;
    while (!(mem_rvalid_i && wb_valid_o) && n < 30) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("bp_rvalid_seen", mem_rvalid_i && wb_valid_o, 1);
    check("bp_ryumi_low", mem_ryumi_o, 0);
    @(negedge clk);
    #2;
    check("bp_still_held", {mem_rvalid_i, wb_valid_o, mem_ryumi_o},
          {1'b1, 1'b1, 1'b0});
    @(negedge clk);
    wb_ready_i = 1'b1;
    #2;
    check("bp_drain_refill", mem_ryumi_o, 1);
    drain("drain_bp");

    // Reset mid-operation
    wb_ready_i = 1'b0;
    issue(0, 2, 0, 32'h100, 0, 8, 32'h3333_3333, 32'h3333_3333, 0);
    n = 0;
    while (!wb_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    rsp_delay = 20;
    issue(0, 2, 0, 32'h104, 0, 9, 32'h4444_4444, 32'h4444_4444, 0);
    issue(0, 2, 0, 32'h108, 0, 10, 32'h5555_5555, 32'h5555_5555, 0);
    #1;
    check("pre_rst_state", {wb_valid_o, busy_o, req_ready_o},
          {1'b1, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_outs", {mem_valid_o, wb_valid_o, busy_o, misalign_o},
          0);
    sb.delete();
    pend.delete();
    rdata_q.delete();
    rsp_delay = 0;
    wb_ready_i = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_outs", {mem_valid_o, wb_valid_o, busy_o, misalign_o,
                           mem_ryumi_o}, 0);
    check("mid_rst_err", err_addr_o, 0);
    check("mid_rst_ready", req_ready_o, 1);
    issue(0, 0, 1, 32'h104, 0, 11, 32'h0000_007F, 32'h0000_007F, 0);
    drain("drain_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
